l2_tlb: RTL

Second-level, fully-associative translation cache between the L1 TLB's `io_l2tlb_req_*`/`io_l2tlb_resp_*` port and the hardware page-table walker. It services one L1 miss at a time. On a hit it returns the cached leaf PTE. On a miss it forwards the request to the walker, returns the walker's PTE to the L1 TLB, and caches valid leaves using first-invalid or else round-robin replacement.

---
 rtl/l2_tlb.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/l2_tlb.sv
// l2_tlb: second-level, fully-associative translation cache between the L1 TLB
// and the hardware page-table walker. One L1 miss is serviced at a time. Hits
// return the cached leaf PTE. Misses are forwarded to the walker, and valid
// leaves returned by the walker are cached. The fill target is the lowest
// invalid entry, or else the round-robin pointer.
// Optional feature: define L2_TLB_PERF_COUNTERS_EN to add the io_perf_hits and
// io_perf_misses counter outputs.
module l2_tlb #(
    parameter int ENTRIES = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_req_ready,
    input  logic        io_req_valid,
    input  logic [26:0] io_req_bits_addr,
    input  logic [1:0]  io_req_bits_prv,
    input  logic        io_req_bits_pum,
    input  logic        io_req_bits_mxr,
    input  logic        io_req_bits_store,
    input  logic        io_req_bits_fetch,
    output logic        io_resp_valid,
    output logic [37:0] io_resp_bits_pte_ppn,
    output logic        io_resp_bits_pte_d,
    output logic        io_resp_bits_pte_a,
    output logic        io_resp_bits_pte_g,
    output logic        io_resp_bits_pte_u,
    output logic        io_resp_bits_pte_x,
    output logic        io_resp_bits_pte_w,
    output logic        io_resp_bits_pte_r,
    output logic        io_resp_bits_pte_v,
    input  logic [6:0]  io_ptw_ptbr_asid,
    input  logic        io_ptw_invalidate,
    input  logic        io_walk_req_ready,
    output logic        io_walk_req_valid,
    output logic [26:0] io_walk_req_bits_addr,
    output logic [1:0]  io_walk_req_bits_prv,
    output logic        io_walk_req_bits_pum,
    output logic        io_walk_req_bits_mxr,
    output logic        io_walk_req_bits_store,
    output logic        io_walk_req_bits_fetch,
    input  logic        io_walk_resp_valid,
    input  logic [37:0] io_walk_resp_bits_pte_ppn,
    input  logic        io_walk_resp_bits_pte_d,
    input  logic        io_walk_resp_bits_pte_a,
    input  logic        io_walk_resp_bits_pte_g,
    input  logic        io_walk_resp_bits_pte_u,
    input  logic        io_walk_resp_bits_pte_x,
    input  logic        io_walk_resp_bits_pte_w,
    input  logic        io_walk_resp_bits_pte_r,
    input  logic        io_walk_resp_bits_pte_v
`ifdef L2_TLB_PERF_COUNTERS_EN
    ,
    output logic [31:0] io_perf_hits,
    output logic [31:0] io_perf_misses
`endif
);

    localparam int IDXW = $clog2(ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WREQ,
        WWAIT,
        RESP
    } state_t;

    state_t state_q;

    // Latched request, the ASID sampled at accept, and the sticky invalidate marker
    logic [26:0]     reqAddr_q;
    logic [1:0]      reqPrv_q;
    logic            reqPum_q;
    logic            reqMxr_q;
    logic            reqStore_q;
    logic            reqFetch_q;
    logic [6:0]      asid_q;
    logic            drop_q;
    logic            respValid_q;
    logic            walkReqValid_q;
    // Response PTE packed as {ppn, d, a, g, u, x, w, r, v}
    logic [45:0]     respPte_q;

    // Entry storage: tag is {asid, vpn}, flags are {d, a, g, u, x, w, r}
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [33:0]        entryTag_q   [ENTRIES];
    logic [37:0]        entryPpn_q   [ENTRIES];
    logic [6:0]         entryFlags_q [ENTRIES];
    logic [IDXW-1:0]    rrPtr_q;
    logic [IDXW-1:0]    rrPtr_d;

    logic            hit;
    logic [IDXW-1:0] hitIdx;
    logic            lookupHit;
    logic            freeFound;
    logic [IDXW-1:0] freeIdx;
    logic [IDXW-1:0] fillIdx;
    logic            fillEn;
    logic [45:0]     walkPte;

    assign walkPte = {io_walk_resp_bits_pte_ppn,
                      io_walk_resp_bits_pte_d, io_walk_resp_bits_pte_a,
                      io_walk_resp_bits_pte_g, io_walk_resp_bits_pte_u,
                      io_walk_resp_bits_pte_x, io_walk_resp_bits_pte_w,
                      io_walk_resp_bits_pte_r, io_walk_resp_bits_pte_v};

    // Associative match against the latched request; descending scan so the lowest index wins
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (entryTag_q[i][26:0] == reqAddr_q) &&
                (entryFlags_q[i][4] || (entryTag_q[i][33:27] == asid_q))) begin
                hit    = 1'b1;
                hitIdx = IDXW'(i);
            end
        end
    end

    // Lowest-index invalid entry, used as the preferred fill slot
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDXW'(i);
            end
        end
    end

    // An invalidate during lookup forces a miss. An invalidate in the fill cycle suppresses the write.
    assign lookupHit = hit && !io_ptw_invalidate;
    assign fillIdx   = freeFound ? freeIdx : rrPtr_q;
    assign fillEn    = (state_q == WWAIT) && io_walk_resp_valid && io_walk_resp_bits_pte_v &&
                       !drop_q && !io_ptw_invalidate;

    // Next valid vector and replacement pointer: flush beats fill; the pointer moves only on eviction
    always_comb begin
        valid_d = valid_q;
        rrPtr_d = rrPtr_q;
        if (io_ptw_invalidate) begin
            valid_d = '0;
        end else if (fillEn) begin
            valid_d[fillIdx] = 1'b1;
            if (!freeFound) begin
                rrPtr_d = rrPtr_q + IDXW'(1);
            end
        end
    end

    // Control FSM with registered handshake outputs and the response register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            respValid_q    <= 1'b0;
            walkReqValid_q <= 1'b0;
            drop_q         <= 1'b0;
            valid_q        <= '0;
            rrPtr_q        <= '0;
            respPte_q      <= '0;
            reqAddr_q      <= '0;
            reqPrv_q       <= '0;
            reqPum_q       <= 1'b0;
            reqMxr_q       <= 1'b0;
            reqStore_q     <= 1'b0;
            reqFetch_q     <= 1'b0;
            asid_q         <= '0;
        end else begin
            valid_q     <= valid_d;
            rrPtr_q     <= rrPtr_d;
            respValid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (io_req_valid) begin
                        reqAddr_q  <= io_req_bits_addr;
                        reqPrv_q   <= io_req_bits_prv;
                        reqPum_q   <= io_req_bits_pum;
                        reqMxr_q   <= io_req_bits_mxr;
                        reqStore_q <= io_req_bits_store;
                        reqFetch_q <= io_req_bits_fetch;
                        asid_q     <= io_ptw_ptbr_asid;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (io_ptw_invalidate) begin
                        drop_q <= 1'b1;
                    end
                    if (lookupHit) begin
                        respPte_q   <= {entryPpn_q[hitIdx], entryFlags_q[hitIdx], 1'b1};
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        walkReqValid_q <= 1'b1;
                        state_q        <= WREQ;
                    end
                end
                WREQ: begin
                    if (io_ptw_invalidate) begin
                        drop_q <= 1'b1;
                    end
                    if (io_walk_req_ready) begin
                        walkReqValid_q <= 1'b0;
                        state_q        <= WWAIT;
                    end
                end
                WWAIT: begin
                    if (io_ptw_invalidate) begin
                        drop_q <= 1'b1;
                    end
                    if (io_walk_resp_valid) begin
                        respPte_q   <= walkPte;
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    drop_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Entry payload write on a qualified walker fill; validity is tracked separately
    always_ff @(posedge clock) begin
        if (fillEn) begin
            entryTag_q[fillIdx]   <= {asid_q, reqAddr_q};
            entryPpn_q[fillIdx]   <= walkPte[45:8];
            entryFlags_q[fillIdx] <= walkPte[7:1];
        end
    end

`ifdef L2_TLB_PERF_COUNTERS_EN
    logic [31:0] perfHits_q;
    logic [31:0] perfMisses_q;

    // Free-running lookup outcome counters; an invalidate does not clear them
    always_ff @(posedge clock) begin
        if (reset) begin
            perfHits_q   <= '0;
            perfMisses_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (lookupHit) begin
                perfHits_q <= perfHits_q + 32'd1;
            end else begin
                perfMisses_q <= perfMisses_q + 32'd1;
            end
        end
    end

    assign io_perf_hits   = perfHits_q;
    assign io_perf_misses = perfMisses_q;
`endif

    assign io_req_ready      = (state_q == IDLE);
    assign io_resp_valid     = respValid_q;
    assign {io_resp_bits_pte_ppn,
            io_resp_bits_pte_d, io_resp_bits_pte_a,
            io_resp_bits_pte_g, io_resp_bits_pte_u,
            io_resp_bits_pte_x, io_resp_bits_pte_w,
            io_resp_bits_pte_r, io_resp_bits_pte_v} = respPte_q;

    assign io_walk_req_valid      = walkReqValid_q;
    assign io_walk_req_bits_addr  = reqAddr_q;
    assign io_walk_req_bits_prv   = reqPrv_q;
    assign io_walk_req_bits_pum   = reqPum_q;
    assign io_walk_req_bits_mxr   = reqMxr_q;
    assign io_walk_req_bits_store = reqStore_q;
    assign io_walk_req_bits_fetch = reqFetch_q;

endmodule
